// File: rtl/if_prefetch_pkg.sv
// Shared fetch-path definitions: bus widths, reset level and pointer sizing helper.
package if_prefetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;
  localparam logic RST_ENABLE = 1'b0;
  localparam logic [INST_DATA_W-1:0] ZERO_WORD = '0;

  // Pointer width for a power-of-two buffer; never below one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// fetch_fifo: synchronous show-ahead FIFO; dout is the head whenever empty is low.
module fetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && rst != RST_ENABLE && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: sequential ROM prefetch into a FIFO feeding ID, with full flush on branch.
// Optional build macro TORU_FETCH_BYPASS_EN lets a response reach ID directly when the FIFO is empty.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int INST_W = INST_DATA_W,
  parameter int DEPTH = 4,
  parameter int ROM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(DEPTH + ROM_LAT + 1) + 1;

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ROM_LAT-1:0]       trk_v;
  logic [ADDR_W-1:0]        trk_pc [ROM_LAT];
  logic                     live;
  logic                     resp_v;
  logic [ADDR_W-1:0]        resp_pc;
  logic                     bypass;
  logic                     head_valid;
  logic [ADDR_W-1:0]        head_pc;
  logic [INST_W-1:0]        head_inst;
  logic                     accept;
  logic                     flush;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_cnt;
  logic [ADDR_W+INST_W-1:0] fifo_dout;
  logic [SW-1:0]            inflight_cnt;
  logic [SW-1:0]            occ;

  assign live    = (rst != RST_ENABLE);
  assign resp_v  = trk_v[ROM_LAT-1];
  assign resp_pc = trk_pc[ROM_LAT-1];

`ifdef TORU_FETCH_BYPASS_EN
  assign bypass = fifo_empty & resp_v;
`else
  assign bypass = 1'b0;
`endif

  assign head_valid = ~fifo_empty | bypass;
  assign head_pc    = bypass ? resp_pc : fifo_dout[ADDR_W+INST_W-1 -: ADDR_W];
  assign head_inst  = bypass ? rom_data_i : fifo_dout[INST_W-1:0];

  // ID handshake: the head transfers in any cycle with id_valid_o high and stall_i low;
  // while stalled id_* hold the same instruction and branch_flag_i has no effect.
  assign id_valid_o = live & head_valid;
  assign id_pc_o    = live ? head_pc : '0;
  assign id_inst_o  = live ? head_inst : INST_W'(ZERO_WORD);

  assign accept    = id_valid_o & ~stall_i;
  assign flush     = accept & branch_flag_i;
  assign fifo_pop  = accept & ~fifo_empty;
  assign fifo_push = resp_v & ~flush & ~(bypass & accept);

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < ROM_LAT; i++) inflight_cnt = inflight_cnt + SW'(trk_v[i]);
  end

  // Credit uses the registered count, so a pop frees its slot only on the next cycle.
  assign occ        = SW'(fifo_cnt) + inflight_cnt;
  assign rom_ce_o   = live & ~flush & (occ < SW'(DEPTH));
  assign rom_addr_o = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      fetch_pc <= RESET_PC;
      trk_v    <= '0;
    end else begin
      if (flush)         fetch_pc <= branch_target_i;
      else if (rom_ce_o) fetch_pc <= fetch_pc + ADDR_W'(4);
      trk_v[0] <= rom_ce_o;
      for (int i = 1; i < ROM_LAT; i++) trk_v[i] <= trk_v[i-1] & ~flush;
    end
  end

  always_ff @(posedge clk) begin
    trk_pc[0] <= fetch_pc;
    for (int i = 1; i < ROM_LAT; i++) trk_pc[i] <= trk_pc[i-1];
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   ({resp_pc, rom_data_i}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch (DEPTH=4, ROM_LAT=1): vector table, directed corner sequences, random run.
module tb_if_prefetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic [31:0] rom_data, rom_addr, id_pc, id_inst;
  logic        rom_ce, id_valid;
  logic [31:0] rom_data_hi, rom_addr_hi, id_pc_hi, id_inst_hi;
  logic        rom_ce_hi, id_valid_hi;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        exp_ce;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] exp_q[$];

  if_prefetch #(.DEPTH(4), .ROM_LAT(1), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .rom_data_i(rom_data), .rom_addr_o(rom_addr), .rom_ce_o(rom_ce),
    .stall_i(stall), .branch_flag_i(branch), .branch_target_i(target),
    .id_pc_o(id_pc), .id_inst_o(id_inst), .id_valid_o(id_valid)
  );

  if_prefetch #(.DEPTH(4), .ROM_LAT(1), .RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .rst(rst), .rom_data_i(rom_data_hi), .rom_addr_o(rom_addr_hi), .rom_ce_o(rom_ce_hi),
    .stall_i(1'b0), .branch_flag_i(1'b0), .branch_target_i(32'h0),
    .id_pc_o(id_pc_hi), .id_inst_o(id_inst_hi), .id_valid_o(id_valid_hi)
  );

  // clock / reset and ROM models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data    <= rom_ce ? (rom_addr ^ K) : 32'hDEAD_BEEF;
    rom_data_hi <= rom_ce_hi ? (rom_addr_hi ^ K) : 32'hDEAD_BEEF;
  end

  // driver / checker tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; branch = b; target = t;
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic ce, input logic ca,
                              input logic [31:0] a, input logic v, input logic [31:0] p);
    vec_t x;
    x.rst = r; x.stall = s; x.exp_ce = ce; x.chk_addr = ca;
    x.exp_addr = a; x.exp_valid = v; x.exp_pc = p;
    return x;
  endfunction

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] issue_exp;
    logic        s, b, acc, fl, found;
    logic [31:0] t;
    int          n_acc;
    int          wait_k;

    rst = 1'b0; stall = 1'b0; branch = 1'b0; target = '0;

    // reset, first issue, stall fill to 4, release in order
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 32'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 32'h04, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 32'h08, 1, 32'h00));
    tbl.push_back(mk(1, 1, 1, 1, 32'h0C, 1, 32'h00));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 0, 1, 32'h10, 1, 32'h00));
    tbl.push_back(mk(1, 0, 0, 1, 32'h10, 1, 32'h00));
    tbl.push_back(mk(1, 0, 1, 1, 32'h10, 1, 32'h04));
    tbl.push_back(mk(1, 0, 1, 1, 32'h14, 1, 32'h08));
    tbl.push_back(mk(1, 0, 1, 1, 32'h18, 1, 32'h0C));
    tbl.push_back(mk(1, 0, 1, 1, 32'h1C, 1, 32'h10));
    tbl.push_back(mk(1, 0, 1, 1, 32'h20, 1, 32'h14));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stall, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_ce", i), {31'b0, rom_ce}, {31'b0, tbl[i].exp_ce});
      chk($sformatf("tbl%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].chk_addr) chk($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].exp_addr);
      if (tbl[i].exp_valid || !tbl[i].rst) begin
        chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_inst", i), id_inst, tbl[i].rst ? (tbl[i].exp_pc ^ K) : 32'h0);
      end
    end

    // reset with FIFO full and a request in flight
    for (int i = 0; i < 6; i++) drive(1, 1, 0, 0);
    chk("full_valid_pre", {31'b0, id_valid}, 32'd1);
    drive(0, 1, 0, 0);
    chk("rst_mid_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_mid_ce", {31'b0, rom_ce}, 32'd0);
    chk("rst_mid_pc", id_pc, 32'h0);
    drive(0, 0, 0, 0);
    chk("rst_mid_valid2", {31'b0, id_valid}, 32'd0);
    drive(1, 0, 0, 0);
    chk("rel_ce", {31'b0, rom_ce}, 32'd1);
    chk("rel_addr", rom_addr, 32'h0);
    chk("rel_valid", {31'b0, id_valid}, 32'd0);
    chk("hi_addr0", rom_addr_hi, 32'hFFFF_FFFC);
    chk("hi_ce0", {31'b0, rom_ce_hi}, 32'd1);
    drive(1, 0, 0, 0);
    chk("hi_addr1", rom_addr_hi, 32'h0000_0000);
    chk("rel_valid1", {31'b0, id_valid}, 32'd0);
    drive(1, 0, 0, 0);
    chk("stream_pc0", id_pc, 32'h0);
    chk("hi_pc0", id_pc_hi, 32'hFFFF_FFFC);
    chk("hi_inst0", id_inst_hi, 32'hFFFF_FFFC ^ K);
    drive(1, 0, 0, 0);
    chk("stream_pc4", id_pc, 32'h4);

    // branch accepted at 0x8 redirects to 0x100
    drive(1, 0, 1, 32'h100);
    chk("br_head", id_pc, 32'h8);
    chk("br_ce_suppressed", {31'b0, rom_ce}, 32'd0);
    found = 1'b0;
    wait_k = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      drive(1, 0, 0, 0);
      if (id_valid) begin found = 1'b1; wait_k = k; end
    end
    chk("br_found", {31'b0, found}, 32'd1);
    chk("br_target_pc", id_pc, 32'h100);
    chk("br_latency", wait_k, 2);
    drive(1, 0, 0, 0);
    chk("br_next_pc", id_pc, 32'h104);

    // stall and branch together: ignored, head holds
    drive(1, 1, 1, 32'h200);
    chk("sb_head0", id_pc, 32'h108);
    drive(1, 1, 1, 32'h200);
    chk("sb_head1", id_pc, 32'h108);
    chk("sb_valid", {31'b0, id_valid}, 32'd1);
    drive(1, 0, 0, 0);
    chk("sb_accept", id_pc, 32'h108);
    drive(1, 0, 0, 0);
    chk("sb_next", id_pc, 32'h10C);

    // random stall/branch against a program-order model
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(32'h0);
    issue_exp = 32'h0;
    n_acc = 0;
    for (int c = 0; c < 600; c++) begin
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 12);
      t = {18'b0, 12'($urandom_range(0, 4095)), 2'b00};
      drive(1, s, b, t);
      acc = id_valid & ~s;
      fl  = acc & b;
      if (acc) begin
        exp_pc = exp_q.pop_front();
        chk("rand_pc", id_pc, exp_pc);
        chk("rand_inst", id_inst, exp_pc ^ K);
        n_acc++;
        exp_q.push_back(fl ? t : exp_pc + 32'd4);
      end
      if (fl) begin
        chk("rand_flush_ce", {31'b0, rom_ce}, 32'd0);
        issue_exp = t;
      end else if (rom_ce) begin
        chk("rand_addr", rom_addr, issue_exp);
        issue_exp = issue_exp + 32'd4;
      end
    end
    chk("rand_progress", {31'b0, n_acc >= 100}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
